state_dump_tx: RTL

- Debug transmitter for the single-cycle CPU. On a trigger it snapshots the PC, then reads the register bank and the first data-memory words through read-only ports.
- It streams them out as a byte frame over a valid/ready interface, for a UART or host link.
- It asserts a freeze request while busy, so the CPU can hold its state during the dump.

---
 rtl/state_dump_tx.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/state_dump_tx.sv
// Debug transmitter: snapshots PC, register bank and data memory into a byte frame.
// Define STATE_DUMP_CSUM_EN to append an 8-bit XOR checksum over the payload bytes.
module state_dump_tx #(
    parameter int unsigned NUM_REGS = 32,
    parameter int unsigned NUM_MEM  = 32,
    parameter logic [7:0]  HDR_BYTE = 8'hA5
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        trig_i,
    input  logic [31:0] pc_i,
    output logic [4:0]  reg_addr_o,
    input  logic [31:0] reg_data_i,
    output logic [31:0] mem_addr_o,
    input  logic [31:0] mem_data_i,
    output logic [7:0]  tx_data_o,
    output logic        tx_valid_o,
    input  logic        tx_ready_i,
    output logic        busy_o,
    output logic        freeze_o,
    output logic        done_o
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_FETCH,
        ST_SEND,
`ifdef STATE_DUMP_CSUM_EN
        ST_CSUM,
`endif
        ST_DONE
    } state_e;

    typedef enum logic [1:0] {
        SRC_PC,
        SRC_REG,
        SRC_MEM
    } src_e;

    state_e      state_q;
    src_e        src_q, src_d;
    logic [31:0] idx_q, idx_d;
    logic        last_word;
    logic [31:0] pc_q;
    logic [31:0] shift_q;
    logic [31:0] word_sel;
    logic [1:0]  byte_cnt_q;
    logic [4:0]  reg_addr_q;
    logic [31:0] mem_addr_q;
    logic [7:0]  tx_data_q;
    logic        tx_valid_q;
    logic        busy_q;
    logic        done_q;
    logic        handshake;
`ifdef STATE_DUMP_CSUM_EN
    logic [7:0]  csum_q;
`endif

    assign handshake = tx_valid_q & tx_ready_i;

    // Successor of the word currently in flight: PC, then registers, then memory.
    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    always_comb begin
        src_d     = src_q;
        idx_d     = idx_q + 32'd1;
        last_word = 1'b0;
        case (src_q)
            SRC_PC: begin
                src_d = SRC_REG;
                idx_d = '0;
            end
            SRC_REG: begin
                if (idx_q == 32'(NUM_REGS - 1)) begin
                    src_d = SRC_MEM;
                    idx_d = '0;
                end
            end
            default: last_word = (idx_q == 32'(NUM_MEM - 1));
        endcase
    end

    always_comb begin
        case (src_q)
            SRC_PC:  word_sel = pc_q;
            SRC_REG: word_sel = reg_data_i;
            default: word_sel = mem_data_i;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            src_q      <= SRC_PC;
            idx_q      <= '0;
            pc_q       <= '0;
            shift_q    <= '0;
            byte_cnt_q <= '0;
            reg_addr_q <= '0;
            mem_addr_q <= '0;
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
`ifdef STATE_DUMP_CSUM_EN
            csum_q     <= '0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (trig_i) begin
                        pc_q       <= pc_i;
                        src_q      <= SRC_PC;
                        idx_q      <= '0;
                        byte_cnt_q <= '0;
                        busy_q     <= 1'b1;
                        tx_valid_q <= 1'b1;
                        tx_data_q  <= HDR_BYTE;
`ifdef STATE_DUMP_CSUM_EN
                        csum_q     <= '0;
`endif
                        state_q    <= ST_HDR;
                    end
                end
                ST_HDR: begin
                    if (handshake) begin
                        tx_valid_q <= 1'b0;
                        state_q    <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    shift_q    <= {word_sel[23:0], 8'h00};
                    tx_data_q  <= word_sel[31:24];
                    tx_valid_q <= 1'b1;
                    byte_cnt_q <= '0;
                    state_q    <= ST_SEND;
                end
                ST_SEND: begin
                    if (handshake) begin
`ifdef STATE_DUMP_CSUM_EN
                        csum_q <= csum_q ^ tx_data_q;
`endif
                        if (byte_cnt_q != 2'd3) begin
                            tx_data_q  <= shift_q[31:24];
                            shift_q    <= {shift_q[23:0], 8'h00};
                            byte_cnt_q <= byte_cnt_q + 2'd1;
                        end else if (last_word) begin
`ifdef STATE_DUMP_CSUM_EN
                            tx_data_q  <= csum_q ^ tx_data_q;
                            state_q    <= ST_CSUM;
`else
                            tx_valid_q <= 1'b0;
                            busy_q     <= 1'b0;
                            done_q     <= 1'b1;
                            state_q    <= ST_DONE;
`endif
                        end else begin
                            tx_valid_q <= 1'b0;
                            src_q      <= src_d;
                            idx_q      <= idx_d;
                            // Only the bank being fetched moves its address; the other holds.
                            if (src_d == SRC_REG) reg_addr_q <= idx_d[4:0];
                            else                  mem_addr_q <= {idx_d[29:0], 2'b00};
                            state_q    <= ST_FETCH;
                        end
                    end
                end
`ifdef STATE_DUMP_CSUM_EN
                ST_CSUM: begin
                    if (handshake) begin
                        tx_valid_q <= 1'b0;
                        busy_q     <= 1'b0;
                        done_q     <= 1'b1;
                        state_q    <= ST_DONE;
                    end
                end
`endif
                ST_DONE: state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign reg_addr_o = reg_addr_q;
    assign mem_addr_o = mem_addr_q;
    assign tx_data_o  = tx_data_q;
    assign tx_valid_o = tx_valid_q;
    assign busy_o     = busy_q;
    assign freeze_o   = busy_q;
    assign done_o     = done_q;

endmodule
